io_uart_tx: RTL and testbench

//  Downstream stage of the test memory-mapped IO window: replaces $write console output with a real serial line.
//  - CPU word writes to the OUT slot push a byte into a TX FIFO; an 8N1 serializer drives it out on tx.
//  - A write to the POWER slot raises halt only after all queued bytes have left the wire.
//  - Sits between the data-memory bus decode and the board/bench UART pin.

---
 rtl/io_uart_tx.sv | 212 +++++++++++++++++++++
 tb/tb_io_uart_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped console UART transmitter (TX FIFO + serializer + drain-then-halt).
// Define UART_PARITY_EN for an even parity bit (8E1); default build is 8N1.
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] memory_in,
  input  logic        address,
  input  logic [3:0]  write_enable,
  output logic [31:0] memory_out,
  output logic        tx,
  output logic        halt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          halt_q;
  logic          halt_pend_q;
  logic          ovf_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  logic       wr;
  logic       wr_out;
  logic       wr_pwr;
  logic       empty;
  logic       full;
  logic       busy;
  logic       bit_end;
  logic       pop;
  logic       push;
  logic [2:0] bit_nxt;
  logic [7:0] rd_data;
  logic       unused_hi;

  assign wr      = (write_enable == 4'b1111);
  assign wr_out  = wr && !address && !halt_pend_q;
  assign wr_pwr  = wr && address;
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH);
  assign busy    = !empty || (state_q != S_IDLE);
  assign bit_end = (clk_cnt_q == BIT_LAST);
  assign bit_nxt = bit_cnt_q + 3'd1;
  assign rd_data = mem_q[rptr_q];
  assign unused_hi = ^memory_in[31:8];

  // The serializer takes a byte when idle or on the last stop cycle.
  assign pop  = !empty && ((state_q == S_IDLE) ||
                ((state_q == S_STOP) && bit_end));
  assign push = wr_out && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= memory_in[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      halt_pend_q <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (wr_out && full && !pop) begin
        ovf_q <= 1'b1;
      end
      if (wr_pwr) begin
        halt_pend_q <= 1'b1;
      end
      if (halt_pend_q && !busy) begin
        halt_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tx_q      <= 1'b1;
          clk_cnt_q <= '0;
          if (pop) begin
            shift_q <= rd_data;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= bit_nxt;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_q    <= ^shift_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              tx_q <= shift_q[bit_nxt];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            tx_q      <= 1'b1;
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (pop) begin
              shift_q <= rd_data;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    memory_out = '0;
    if (address) begin
      memory_out[1:0] = {halt_q, halt_pend_q};
    end else begin
      memory_out[2:0] = {ovf_q, full, busy};
    end
  end

  assign tx   = tx_q;
  assign halt = halt_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: scoreboard bench for io_uart_tx, line monitor decodes frames.
// Build with UART_PARITY_EN to cover the 8E1 frame.
module tb_io_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] memory_in = '0;
  logic        address = 1'b0;
  logic [3:0]  write_enable = '0;
  logic [31:0] memory_out;
  logic        tx;
  logic        halt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_cyc  = 0;
  int last_end = -1;
  logic [7:0] exp_q[$];
  int start_q[$];

  io_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .memory_in(memory_in),
    .address(address),
    .write_enable(write_enable),
    .memory_out(memory_out),
    .tx(tx),
    .halt(halt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic a, input logic [31:0] d,
                    input logic [3:0] we);
    @(negedge clk);
    address = a;
    memory_in = d;
    write_enable = we;
    @(posedge clk);
    #1;
    wr_cyc = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    write_enable = 4'h0;
    address = 1'b0;
  endtask

  task automatic rd(input logic a, output logic [31:0] v);
    address = a;
    #1;
    v = memory_out;
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      address = 1'b0;
      #1;
      if (exp_q.size() == 0 && memory_out[0] == 1'b0) done = 1'b1;
    end
    chk("idle_timeout", 32'(done), 32'd1);
  endtask

  initial begin : mon
    logic [NB-1:0] bits;
    logic stable;
    logic abort;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        start_q.push_back(cyc);
        stable = 1'b1;
        abort = 1'b0;
        bits = '0;
        for (int b = 0; b < NB && !abort; b++) begin
          for (int c = 0; c < CPB && !abort; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!rst_n) abort = 1'b1;
            else if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) stable = 1'b0;
          end
        end
        if (abort) begin
          wait (rst_n);
        end else begin
          last_end = cyc;
          chk("bit_width", 32'(stable), 32'd1);
          chk("start_bit", 32'(bits[0]), 32'd0);
          chk("stop_bit", 32'(bits[NB-1]), 32'd1);
`ifdef UART_PARITY_EN
          chk("parity", 32'(bits[9]), 32'(^bits[8:1]));
`endif
          chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) chk("rx_byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : main
    logic [31:0] v;
    int n0;
    int wc;
    int hc;

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_halt", 32'(halt), 32'd0);
    rd(1'b0, v);
    chk("rst_st0", v, 32'd0);
    rd(1'b1, v);
    chk("rst_st1", v, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single frame, latency and busy
    n0 = start_q.size();
    exp_q.push_back(8'h41);
    wr(1'b0, 32'hFFFF_FF41, 4'hF);
    wc = wr_cyc;
    idle();
    rd(1'b0, v);
    chk("t1_busy", v, 32'd1);
    wait_idle(100);
    chk("t1_frames", 32'(start_q.size() - n0), 32'd1);
    if (start_q.size() > n0) chk("t1_lat", 32'(start_q[n0]), 32'(wc + 1));
    rd(1'b0, v);
    chk("t1_done", v, 32'd0);

    // back-to-back frames are contiguous
    n0 = start_q.size();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    wr(1'b0, 32'h55, 4'hF);
    wr(1'b0, 32'hAA, 4'hF);
    idle();
    wait_idle(200);
    chk("t2_frames", 32'(start_q.size() - n0), 32'd2);
    if (start_q.size() > n0 + 1)
      chk("t2_gap", 32'(start_q[n0+1] - start_q[n0]), 32'(NB * CPB));

    // overflow: six writes, fifth fills, sixth dropped
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < 6; i++) wr(1'b0, 32'(8'h10 + i), 4'hF);
    idle();
    rd(1'b0, v);
    chk("t3_full", v, 32'd7);
    wait_idle(400);
    rd(1'b0, v);
    chk("t3_ovf", v, 32'd4);

    // partial strobes are ignored
    n0 = start_q.size();
    wr(1'b0, 32'h99, 4'b0001);
    wr(1'b0, 32'h98, 4'b0111);
    wr(1'b1, 32'h0, 4'b1110);
    idle();
    repeat (20) @(negedge clk);
    chk("t4_tx", 32'(tx), 32'd1);
    chk("t4_frames", 32'(start_q.size() - n0), 32'd0);
    rd(1'b0, v);
    chk("t4_st0", v, 32'd4);
    rd(1'b1, v);
    chk("t4_st1", v, 32'd0);

    // drain then halt
    n0 = start_q.size();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    wr(1'b0, 32'h0D, 4'hF);
    wr(1'b0, 32'h0A, 4'hF);
    wr(1'b1, 32'hDEAD_BEEF, 4'hF);
    idle();
    rd(1'b1, v);
    chk("t5_pend", v, 32'd1);
    hc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (halt === 1'b1) begin
        hc = cyc;
        break;
      end
    end
    chk("t5_halt_seen", 32'(hc >= 0), 32'd1);
    chk("t5_halt_cyc", 32'(hc), 32'(last_end + 2));
    chk("t5_frames", 32'(start_q.size() - n0), 32'd2);
    wr(1'b0, 32'h33, 4'hF);
    idle();
    repeat (60) @(negedge clk);
    chk("t5_no_tx", 32'(start_q.size() - n0), 32'd2);
    rd(1'b1, v);
    chk("t5_st1", v, 32'd3);
    rd(1'b0, v);
    chk("t5_st0", v, 32'd4);

    // reset mid-DATA; halt_pending blocks OUT, so reset first
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr(1'b0, 32'h00, 4'hF);
    idle();
    repeat (10) @(negedge clk);
    chk("t6_pre_tx", 32'(tx), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_tx", 32'(tx), 32'd1);
    chk("t6_halt", 32'(halt), 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    rd(1'b0, v);
    chk("t6_st0", v, 32'd0);
    rd(1'b1, v);
    chk("t6_st1", v, 32'd0);

    // recovery frame; parity 1 under 8E1
    n0 = start_q.size();
    exp_q.push_back(8'h07);
    wr(1'b0, 32'h07, 4'hF);
    idle();
    wait_idle(100);
    chk("t7_frames", 32'(start_q.size() - n0), 32'd1);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
